// File: rtl/paint_brush_writer.sv
// paint_brush_writer: turns cursor, tool state and button edges into a
// raster of framebuffer writes covering a clipped square brush footprint.
module paint_brush_writer #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int COLOR_W   = 3,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_W    = 19,
    parameter int NUM_SIZES = 4,
    parameter int SIZE_STEP = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [X_W-1:0]     x_pos,
    input  logic [Y_W-1:0]     y_pos,
    input  logic               tool_on,
    input  logic               tool_sel,
    input  logic               size_sel,
    input  logic [COLOR_W-1:0] color,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               mode,
    output logic [((NUM_SIZES > 1) ? $clog2(NUM_SIZES) : 1)-1:0] size_idx,
    output logic               stamp_done
);

    localparam int SIZE_W = (NUM_SIZES > 1) ? $clog2(NUM_SIZES) : 1;
    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);
    localparam logic [SIZE_W-1:0] SIZE_LAST = SIZE_W'(NUM_SIZES - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t state_q, state_d;

    logic tool_sel_q, tool_sel_d;
    logic size_sel_q, size_sel_d;
    logic mode_q, mode_d;
    logic [SIZE_W-1:0] size_idx_q, size_idx_d;

    logic [X_W-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
    logic [Y_W-1:0] y_q, y_d, y1_q, y1_d, cy_q, cy_d;
    logic [ADDR_W-1:0] addr_q, addr_d, row_q, row_d;
    logic [COLOR_W-1:0] data_q, data_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [X_W-1:0] last_x_q, last_x_d;
    logic [Y_W-1:0] last_y_q, last_y_d;
    logic last_vld_q, last_vld_d;

    logic [X_W-1:0] cx_c;
    logic [Y_W-1:0] cy_c;
    logic trigger;
    int r_i, x0_i, x1_i, y0_i, y1_i, start_i;

    // Clamp the cursor, derive clipped bounds and compute next state.
    always_comb begin
        cx_c = (x_pos > X_MAX) ? X_MAX : x_pos;
        cy_c = (y_pos > Y_MAX) ? Y_MAX : y_pos;

        // Widened signed math so bounds near the edges never wrap.
        r_i  = int'(size_idx_q) * SIZE_STEP;
        x0_i = int'(cx_c) - r_i;
        x1_i = int'(cx_c) + r_i;
        y0_i = int'(cy_c) - r_i;
        y1_i = int'(cy_c) + r_i;
        if (x0_i < 0) x0_i = 0;
        if (y0_i < 0) y0_i = 0;
        if (x1_i > H_RES - 1) x1_i = H_RES - 1;
        if (y1_i > V_RES - 1) y1_i = V_RES - 1;
        start_i = y0_i * H_RES + x0_i;

        trigger = tool_on &&
                  (!last_vld_q || cx_c != last_x_q || cy_c != last_y_q);

        state_d    = state_q;
        tool_sel_d = tool_sel;
        size_sel_d = size_sel;
        mode_d     = mode_q ^ (tool_sel & ~tool_sel_q);
        size_idx_d = size_idx_q;
        if (size_sel && !size_sel_q) begin
            size_idx_d = (size_idx_q == SIZE_LAST) ? '0
                                                   : size_idx_q + SIZE_W'(1);
        end

        x_d        = x_q;
        y_d        = y_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        addr_d     = addr_q;
        row_d      = row_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_vld_d = last_vld_q;

        case (state_q)
            IDLE: begin
                if (!tool_on) begin
                    last_vld_d = 1'b0;
                end else if (trigger) begin
                    cx_d    = cx_c;
                    cy_d    = cy_c;
                    x0_d    = X_W'(x0_i);
                    x1_d    = X_W'(x1_i);
                    y1_d    = Y_W'(y1_i);
                    x_d     = X_W'(x0_i);
                    y_d     = Y_W'(y0_i);
                    addr_d  = ADDR_W'(start_i);
                    row_d   = ADDR_W'(start_i);
                    data_d  = mode_q ? '0 : color;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (valid_q && wr_ready) begin
                    if (x_q != x1_q) begin
                        x_d    = x_q + X_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (y_q != y1_q) begin
                        x_d    = x0_q;
                        y_d    = y_q + Y_W'(1);
                        row_d  = row_q + ADDR_W'(H_RES);
                        addr_d = row_q + ADDR_W'(H_RES);
                    end else begin
                        valid_d    = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        last_x_d   = cx_q;
                        last_y_d   = cy_q;
                        last_vld_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; clr abandons any stamp in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            tool_sel_q <= 1'b0;
            size_sel_q <= 1'b0;
            mode_q     <= 1'b0;
            size_idx_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            addr_q     <= '0;
            row_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_x_q   <= '0;
            last_y_q   <= '0;
            last_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tool_sel_q <= tool_sel_d;
            size_sel_q <= size_sel_d;
            mode_q     <= mode_d;
            size_idx_q <= size_idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_vld_q <= last_vld_d;
        end
    end

    assign wr_valid   = valid_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign busy       = busy_q;
    assign mode       = mode_q;
    assign size_idx   = size_idx_q;
    assign stamp_done = done_q;

endmodule
